// File: rtl/hcsr04_axil_slave.sv
// hcsr04_axil_slave: AXI4-Lite register block for an HC-SR04 ultrasonic ranger.
// Generates the trigger pulse, times the synchronised echo and reports via
// CTRL/PERIOD/STATUS/ECHO_CYCLES. Define HCSR04_IRQ_EN to add irq_o and the
// CTRL[3] interrupt mask.
module hcsr04_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int TRIG_CYCLES        = 1000,
  parameter int TIMEOUT_CYCLES     = 3800000,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            trig_o,
  input  logic                            echo_i
`ifdef HCSR04_IRQ_EN
  ,
  output logic                            irq_o
`endif
);

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TMO       = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT_RISE, MEASURE} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    echo_s;
  logic                    awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]             rdata_q, rmux;
  logic                    en_q, start_q, pend_q, valid_q, timeout_q;
  logic [31:0]             period_q, per_q, echo_q;
  logic [15:0]             mcnt_q;
  logic                    mask_w;
  logic                    wr_en, rd_en, wr_ctrl, clr_to, echo_rd, per_hit;
  logic                    go, launch, cap_ok, cap_to, rise_to;
  logic                    unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign echo_s  = sync_q[SYNC_STAGES-1];
  assign wr_en   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en   = arready_q & S_AXI_ARVALID;
  assign wr_ctrl = wr_en & (S_AXI_AWADDR[3:2] == 2'd0) & S_AXI_WSTRB[0];
  assign clr_to  = wr_ctrl & S_AXI_WDATA[2];
  assign echo_rd = rd_en & (S_AXI_ARADDR[3:2] == 2'd3);
  assign per_hit = en_q & (period_q != 32'd0) & (per_q == period_q - 32'd1);
  // PERIOD=0 in periodic mode retriggers as soon as the FSM is back in IDLE
  assign go      = start_q | pend_q | (en_q & (period_q == 32'd0));

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  // Decoded from the async-reset state register so reset drops it at once
  assign trig_o        = (state_q == TRIG);

  // Write channel: take address+data together, hold BVALID until BREADY
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
      if (wr_en)             bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
    end
  end

  // Register read mux, sampled into RDATA at the address handshake
  always_comb begin
    rmux = 32'd0;
    case (S_AXI_ARADDR[3:2])
      2'd0: rmux = {28'd0, mask_w, 2'b00, en_q};
      2'd1: rmux = period_q;
      2'd2: rmux = {mcnt_q, 13'd0, timeout_q, valid_q, state_q != IDLE};
      default: rmux = echo_q;
    endcase
  end

  // Read channel: RDATA/RVALID held stable until RREADY
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rmux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // CTRL/PERIOD writes, period counter, pending trigger and result registers
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      en_q      <= 1'b0;
      start_q   <= 1'b0;
      period_q  <= 32'd0;
      per_q     <= 32'd0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      mcnt_q    <= 16'd0;
      echo_q    <= 32'd0;
      sync_q    <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], echo_i};
      start_q <= wr_ctrl & S_AXI_WDATA[1];
      if (wr_ctrl) en_q <= S_AXI_WDATA[0];
      for (int b = 0; b < 4; b++)
        if (wr_en && S_AXI_AWADDR[3:2] == 2'd1 && S_AXI_WSTRB[b])
          period_q[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      if (!en_q || per_hit) per_q <= 32'd0;
      else                  per_q <= per_q + 32'd1;
      if (per_hit)     pend_q <= 1'b1;
      else if (launch) pend_q <= 1'b0;
      if (cap_ok) begin
        echo_q  <= cnt_q;
        valid_q <= 1'b1;
        mcnt_q  <= mcnt_q + 16'd1;
      end else if (echo_rd) begin
        valid_q <= 1'b0;
      end
      if (cap_to) echo_q <= 32'hFFFF_FFFF;
      if (cap_to || rise_to) timeout_q <= 1'b1;
      else if (clr_to)       timeout_q <= 1'b0;
    end
  end

`ifdef HCSR04_IRQ_EN
  logic mask_q, irq_q;
  assign mask_w = mask_q;
  assign irq_o  = irq_q & mask_q;
  // IRQ mask and sticky done/timeout event
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      mask_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_ctrl) mask_q <= S_AXI_WDATA[3];
      if (cap_ok || cap_to || rise_to) irq_q <= 1'b1;
      else if (echo_rd || clr_to)      irq_q <= 1'b0;
    end
  end
`else
  assign mask_w = 1'b0;
`endif

  // FSM state and shared cycle counter
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: trigger, wait for echo rise, time echo width
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    cap_ok  = 1'b0;
    cap_to  = 1'b0;
    rise_to = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        state_d = TRIG;
        cnt_d   = 32'd0;
        launch  = 1'b1;
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = 32'd0;
        end else cnt_d = cnt_q + 32'd1;
      end
      WAIT_RISE: begin
        if (echo_s) begin
          state_d = MEASURE;
          cnt_d   = 32'd1;
        end else if (cnt_q == TMO_LAST) begin
          state_d = IDLE;
          rise_to = 1'b1;
        end else cnt_d = cnt_q + 32'd1;
      end
      default: begin
        if (!echo_s) begin
          state_d = IDLE;
          cap_ok  = 1'b1;
        end else if (cnt_q + 32'd1 == TMO) begin
          state_d = IDLE;
          cap_to  = 1'b1;
        end else cnt_d = cnt_q + 32'd1;
      end
    endcase
  end

endmodule

// File: tb/tb_hcsr04_axil_slave.sv
// Scoreboard bench for hcsr04_axil_slave: reads/writes push expectations,
// a monitor pops them on each R/B handshake. Echo pulses are random.
module tb_hcsr04_axil_slave;
  localparam int TRIG = 10;
  localparam int TMO  = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, trig, echo = 0;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
`ifdef HCSR04_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  hcsr04_axil_slave #(.TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .trig_o(trig), .echo_i(echo)
`ifdef HCSR04_IRQ_EN
    , .irq_o(irq)
`endif
  );

  int n_chk = 0, n_fail = 0, cyc = 0, bq = 0;
  logic [31:0] rq[$];
  string       rn[$];

  // reference model of the programmer-visible state
  logic        m_en = 0, m_mask = 0, m_valid = 0, m_to = 0;
  logic [31:0] m_period = 0, m_echo = 0;
  logic [15:0] m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] e_status();
    return {m_cnt, 13'd0, m_to, m_valid, 1'b0};
  endfunction

  function automatic logic [31:0] e_ctrl();
    return {28'd0, m_mask, 2'b00, m_en};
  endfunction

  // response monitor
  always @(negedge clk) begin
    if (rvalid && rready) begin
      if (rq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL r_unexpected: got RVALID with data %h, expected none", rdata);
      end else begin
        chk(rn.pop_front(), rdata, rq.pop_front());
        chk("rresp", {30'd0, rresp}, 32'd0);
      end
    end
    if (bvalid && bready) begin
      if (bq == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected: got BVALID, expected none");
      end else begin
        bq--;
        chk("bresp", {30'd0, bresp}, 32'd0);
      end
    end
  end

  task automatic axw(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bq++;
    for (int n = 0; n < 50 && !awready; n++) @(negedge clk);
    chk("awready", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    case (a[3:2])
      2'd0: if (s[0]) begin
        m_en = d[0];
`ifdef HCSR04_IRQ_EN
        m_mask = d[3];
`endif
        if (d[2]) m_to = 0;
      end
      2'd1: for (int b = 0; b < 4; b++) if (s[b]) m_period[8*b +: 8] = d[8*b +: 8];
      default: ;
    endcase
    if (bready) for (int n = 0; n < 50 && bq != 0; n++) @(negedge clk);
  endtask

  task automatic axr(input logic [3:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    araddr = a; arvalid = 1; rq.push_back(exp); rn.push_back(nm);
    for (int n = 0; n < 50 && !arready; n++) @(negedge clk);
    chk("arready", {31'd0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 0;
    if (a[3:2] == 2'd3) m_valid = 0;
    if (rready) for (int n = 0; n < 50 && rq.size() != 0; n++) @(negedge clk);
  endtask

  task automatic wait_trig(output int t);
    for (int n = 0; n < 5000 && !trig; n++) @(negedge clk);
    chk("trig_rise", {31'd0, trig}, 32'd1);
    t = cyc;
  endtask

  task automatic trig_width();
    int hi = 0;
    while (trig && hi < 100) begin hi++; @(negedge clk); end
    chk("trig_width", hi, TRIG);
  endtask

  task automatic echo_pulse(input int gap, input int w);
    repeat (gap) @(negedge clk);
    echo = 1;
    repeat (w) @(negedge clk);
    echo = 0;
    repeat (8) @(negedge clk);
    m_echo = w; m_valid = 1; m_cnt++;
  endtask

  task automatic measure(input int gap, input int w, output int t);
    wait_trig(t);
    trig_width();
    echo_pulse(gap, w);
  endtask

  task automatic do_reset();
    #2 rst = 1;
    #1 chk("trig_in_reset", {31'd0, trig}, 32'd0);
    echo = 0; awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    m_en = 0; m_mask = 0; m_valid = 0; m_to = 0; m_period = 0; m_echo = 0; m_cnt = 0;
  endtask

  initial begin
    int t, tp[3], gap, w;
    logic [31:0] d;
    logic [3:0]  s;
    repeat (3) @(negedge clk);
    chk("rst_out", {25'd0, awready, wready, bvalid, arready, rvalid, trig, 1'b0}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
`ifdef HCSR04_IRQ_EN
    chk("rst_irq", {31'd0, irq}, 32'd0);
`endif
    rst = 0;
    repeat (2) @(negedge clk);

    axr(4'h0, 32'd0, "ctrl_reset");
    axr(4'h8, 32'd0, "status_reset");
    axw(4'h4, 32'h123, 4'hF);
    axr(4'h4, m_period, "period_123");
    axw(4'h4, 32'hFFFF_FFFF, 4'h1);
    axr(4'h4, m_period, "period_strb");
    axw(4'hC, 32'hDEAD_BEEF, 4'hF);
    axw(4'h8, 32'hFFFF_FFFF, 4'hF);
    axr(4'hC, m_echo, "echo_ro");
    axr(4'h8, e_status(), "status_ro");
    for (int i = 0; i < 4; i++) begin
      d = $urandom; s = 4'($urandom_range(1, 15));
      axw(4'h4, d, s);
      axr(4'h4, m_period, "period_rand");
    end

    // single shot, fixed pulse
    axw(4'h0, 32'h2, 4'h1);
    measure(20, 500, t);
    axr(4'h8, e_status(), "status_shot");
    axr(4'hC, m_echo, "echo_500");
    axr(4'h8, e_status(), "status_after_rd");

    // single shots, random pulses
    for (int i = 0; i < 3; i++) begin
      gap = $urandom_range(1, 40); w = $urandom_range(1, 400);
      axw(4'h0, 32'h2, 4'h1);
      measure(gap, w, t);
      axr(4'h8, e_status(), "status_rand");
      axr(4'hC, m_echo, "echo_rand");
    end

    // no echo -> timeout
    axw(4'h0, 32'h2, 4'h1);
    wait_trig(t);
    trig_width();
    repeat (TMO + 5) @(negedge clk);
    m_to = 1;
    axr(4'h8, e_status(), "status_timeout");
    axw(4'h0, 32'h4, 4'h1);
    axr(4'h8, e_status(), "status_to_clr");

    // back-pressure on B and R
    bready = 0;
    axw(4'h4, 32'h55, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bvalid_hold", {30'd0, bvalid, awready}, 32'h2);
    end
    bready = 1;
    for (int n = 0; n < 50 && bq != 0; n++) @(negedge clk);
    rready = 0;
    axr(4'h4, m_period, "period_hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rvalid_hold", {30'd0, rvalid, arready}, 32'h2);
      chk("rdata_hold", rdata, m_period);
    end
    rready = 1;
    for (int n = 0; n < 50 && rq.size() != 0; n++) @(negedge clk);

    // periodic triggering
    axw(4'h4, 32'd3000, 4'hF);
    axw(4'h0, 32'h1, 4'h1);
    for (int k = 0; k < 3; k++) measure(5, 100, tp[k]);
    axw(4'h0, 32'h0, 4'h1);
    chk("period_gap1", tp[1] - tp[0], 3000);
    chk("period_gap2", tp[2] - tp[1], 3000);
    axr(4'h8, e_status(), "status_periodic");
    axr(4'hC, m_echo, "echo_periodic");

    // reset mid-measure
    axw(4'h0, 32'h2, 4'h1);
    wait_trig(t);
    trig_width();
    repeat (5) @(negedge clk);
    echo = 1;
    repeat (50) @(negedge clk);
    do_reset();
    axr(4'h0, 32'd0, "ctrl_post_rst");
    axr(4'h4, 32'd0, "period_post_rst");
    axr(4'h8, 32'd0, "status_post_rst");
    axr(4'hC, 32'd0, "echo_post_rst");
    axw(4'h0, 32'h2, 4'h1);
    measure(7, 321, t);
    axr(4'h8, e_status(), "status_post_rst_shot");
    axr(4'hC, m_echo, "echo_post_rst_shot");

    // reset while trigger is high
    axw(4'h0, 32'h2, 4'h1);
    wait_trig(t);
    do_reset();
    axr(4'h8, 32'd0, "status_rst_trig");

`ifdef HCSR04_IRQ_EN
    axw(4'h0, 32'hA, 4'h1);
    axr(4'h0, e_ctrl(), "ctrl_mask");
    measure(20, 500, t);
    chk("irq_set", {31'd0, irq}, 32'd1);
    axr(4'hC, m_echo, "echo_irq");
    chk("irq_clr", {31'd0, irq}, 32'd0);
`else
    axw(4'h0, 32'h9, 4'h1);
    axr(4'h0, e_ctrl(), "ctrl_no_mask");
    axw(4'h0, 32'h0, 4'h1);
`endif

    repeat (5) @(negedge clk);
    if (rq.size() != 0 || bq != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d reads and %0d writes outstanding, expected 0", rq.size(), bq);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
